// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared types and constants for the program-counter unit
package pc_unit_pkg;

    typedef enum logic {
        BOOT,
        RUN
    } pc_state_e;

    // Low PC bits that must be zero for a legal fetch target
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    localparam logic [63:0] DEFAULT_RESET_VEC = 64'h0;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-control bundle between the core and the PC unit
interface pc_unit_if #(
    parameter int XLEN = 64
);
    logic            stall_i;
    logic            redirect_valid_i;
    logic [XLEN-1:0] redirect_target_i;
    logic            trap_i;
    logic [XLEN-1:0] trap_vec_i;
    logic            ras_push_i;
    logic            ras_pop_i;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic            misalign_o;
    logic [XLEN-1:0] ras_top_o;
    logic            ras_empty_o;

    modport master (
        output stall_i, redirect_valid_i, redirect_target_i, trap_i, trap_vec_i,
               ras_push_i, ras_pop_i,
        input  pc_o, pc_valid_o, misalign_o, ras_top_o, ras_empty_o
    );

    modport slave (
        input  stall_i, redirect_valid_i, redirect_target_i, trap_i, trap_vec_i,
               ras_push_i, ras_pop_i,
        output pc_o, pc_valid_o, misalign_o, ras_top_o, ras_empty_o
    );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_up;
    logic [PW-1:0]   ptr_dn;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] top_q;
    logic            pop_ok;

    // ptr addresses the top entry; a pop on an empty stack is dropped
    always_comb begin
        pop_ok = pop_i && cnt != '0;
        ptr_up = ptr + 1'b1;
        ptr_dn = ptr - 1'b1;
    end

    // Entry storage: push+pop rewrites the top in place, plain push advances
    always_ff @(posedge clk) begin
        if (push_i)
            mem[pop_ok ? ptr : ptr_up] <= push_data_i;
    end

    // Pointer, occupancy and registered top-of-stack copy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            cnt   <= '0;
            top_q <= '0;
        end else if (push_i && pop_ok) begin
            top_q <= push_data_i;
        end else if (push_i) begin
            ptr   <= ptr_up;
            cnt   <= (cnt == CW'(DEPTH)) ? cnt : cnt + 1'b1;
            top_q <= push_data_i;
        end else if (pop_ok) begin
            ptr   <= ptr_dn;
            cnt   <= cnt - 1'b1;
            top_q <= (cnt == CW'(1)) ? '0 : mem[ptr_dn];
        end
    end

    assign top_o   = top_q;
    assign empty_o = (cnt == '0);

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch PC register with trap/redirect/stall next-PC selection and boot bubble; PC_RAS_EN adds a return-address stack
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input logic         clk,
    input logic         reset,
    pc_unit_if.slave    bus
);
    pc_state_e       state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] pc_next;
    logic            valid_q;
    logic            misalign_q;
    logic            bad_target;
    logic            misalign_next;

    // Next-PC select: trap beats redirect beats stall; a misaligned redirect freezes the PC
    always_comb begin
        pc_inc        = pc_q + XLEN'(INC);
        bad_target    = |(bus.redirect_target_i[1:0] & ALIGN_MASK);
        pc_next       = bus.trap_i ? (bus.trap_vec_i & ~XLEN'(ALIGN_MASK)) :
                        bus.redirect_valid_i ? (bad_target ? pc_q : bus.redirect_target_i) :
                        bus.stall_i ? pc_q : pc_inc;
        misalign_next = bus.redirect_valid_i && bad_target && !bus.trap_i;
    end

    // BOOT holds RESET_VEC for one bubble cycle, then RUN follows the next-PC select
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            pc_q       <= RESET_VEC;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else if (state == BOOT) begin
            state      <= RUN;
            valid_q    <= 1'b1;
        end else begin
            pc_q       <= pc_next;
            misalign_q <= misalign_next;
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_valid_o = valid_q;
    assign bus.misalign_o = misalign_q;

`ifdef PC_RAS_EN
    logic ras_op_en;

    assign ras_op_en = (state == RUN) && !bus.stall_i;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (ras_op_en && bus.ras_push_i),
        .pop_i       (ras_op_en && bus.ras_pop_i),
        .push_data_i (pc_inc),
        .top_o       (bus.ras_top_o),
        .empty_o     (bus.ras_empty_o)
    );
`else
    logic unused_ras;

    assign unused_ras      = ^{bus.ras_push_i, bus.ras_pop_i};
    assign bus.ras_top_o   = '0;
    assign bus.ras_empty_o = 1'b1;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and random checks of pc_unit against a rule-level reference model
module tb_pc_unit;
    localparam int          XLEN  = 64;
    localparam logic [63:0] RVEC  = 64'h1000;
    localparam int          DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic        m_run;
    logic [63:0] m_pc;
    logic        m_mis;
    logic [63:0] m_ras[$];

    pc_unit_if #(.XLEN(XLEN)) bus();

    pc_unit #(
        .XLEN      (XLEN),
        .RESET_VEC (RVEC),
        .INC       (4),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        logic [63:0] top;
        top = (m_ras.size() == 0) ? 64'h0 : m_ras[$];
        chk("pc", bus.pc_o, m_pc);
        chk("valid", 64'(bus.pc_valid_o), 64'(m_run));
        chk("misalign", 64'(bus.misalign_o), 64'(m_mis));
        chk("ras_top", bus.ras_top_o, top);
        chk("ras_empty", 64'(bus.ras_empty_o), 64'(m_ras.size() == 0));
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_pc  = RVEC;
        m_mis = 1'b0;
        m_ras.delete();
    endtask

    task automatic set_in(input logic st, input logic rv, input logic [63:0] tgt,
                          input logic tr, input logic [63:0] vec, input logic pu, input logic po);
        bus.stall_i           = st;
        bus.redirect_valid_i  = rv;
        bus.redirect_target_i = tgt;
        bus.trap_i            = tr;
        bus.trap_vec_i        = vec;
        bus.ras_push_i        = pu;
        bus.ras_pop_i         = po;
    endtask

    // One clock: advance the model by the rules, then check every output 1 time unit after the edge
    task automatic cycle();
        logic [63:0] npc;
        logic        nmis;
        npc  = m_pc;
        nmis = 1'b0;
        if (m_run) begin
`ifdef PC_RAS_EN
            if (!bus.stall_i) begin
                if (bus.ras_push_i && bus.ras_pop_i && m_ras.size() > 0) begin
                    m_ras[m_ras.size()-1] = m_pc + 64'd4;
                end else if (bus.ras_push_i) begin
                    if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
                    m_ras.push_back(m_pc + 64'd4);
                end else if (bus.ras_pop_i && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
`endif
            if (bus.trap_i) npc = {bus.trap_vec_i[63:2], 2'b00};
            else if (bus.redirect_valid_i && bus.redirect_target_i[1:0] != 2'b00) nmis = 1'b1;
            else if (bus.redirect_valid_i) npc = bus.redirect_target_i;
            else if (!bus.stall_i) npc = m_pc + 64'd4;
        end
        @(posedge clk);
        #1;
        m_run = 1'b1;
        m_pc  = npc;
        m_mis = nmis;
        chk_all();
    endtask

    initial begin
        logic [63:0] t;
        set_in(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all();
        reset = 1'b0;
        #1;
        chk("boot_pc", bus.pc_o, 64'h1000);
        chk("boot_valid", 64'(bus.pc_valid_o), 64'h0);
        repeat (3) cycle();
        chk("seq_pc", bus.pc_o, 64'h1008);
        set_in(1, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();
        chk("stall_hold", bus.pc_o, 64'h1008);
        set_in(1, 1, 64'h2000, 0, 0, 0, 0);
        cycle();
        chk("redir_stall", bus.pc_o, 64'h2000);
        set_in(0, 1, 64'h2002, 0, 0, 0, 0);
        cycle();
        chk("mis_pulse", 64'(bus.misalign_o), 64'h1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("mis_clear", 64'(bus.misalign_o), 64'h0);
        set_in(0, 1, 64'h2002, 1, 64'h3003, 0, 0);
        cycle();
        chk("trap_pc", bus.pc_o, 64'h3000);
        set_in(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("wrap", bus.pc_o, 64'h0);
        set_in(0, 1, 64'h100, 0, 0, 0, 0);
        cycle();
        for (int k = 1; k <= 5; k++) begin
            set_in(0, 1, 64'(k + 1) << 8, 0, 0, 1, 0);
            cycle();
        end
`ifdef PC_RAS_EN
        chk("ras_five", bus.ras_top_o, 64'h504);
`endif
        for (int k = 0; k < 5; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 1);
            cycle();
        end
        chk("ras_drained", 64'(bus.ras_empty_o), 64'h1);
        for (int n = 0; n < 400; n++) begin
            t = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) t[1:0] = 2'b00;
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, t,
                   $urandom_range(0, 15) == 0, {$urandom, $urandom},
                   $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
            cycle();
        end
        set_in(0, 1, 64'h100, 0, 0, 0, 0);
        cycle();
        set_in(0, 1, 64'h4000, 0, 0, 1, 0);
        cycle();
        set_in(0, 1, 64'h5000, 0, 0, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_pc", bus.pc_o, 64'h1000);
        chk("async_empty", 64'(bus.ras_empty_o), 64'h1);
        chk("async_valid", 64'(bus.pc_valid_o), 64'h0);
        chk("async_top", bus.ras_top_o, 64'h0);
        @(posedge clk);
        #1;
        chk_all();
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the RISC-V core; successor to the plain 64-bit PC register. Holds the fetch PC and selects the next PC from sequential increment, branch/jump redirect or trap vector, with stall and a post-reset boot bubble. It flags misaligned redirect targets and optionally contains a return-address stack. Sits at the head of the fetch stage, feeding instruction memory and the PC adder.

## Interface
- XLEN, 64, PC width in bits.
- RESET_VEC, 0, PC value loaded on reset (XLEN bits).
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- stall_i  in  1  hold PC this cycle.
- redirect_valid_i  in  1  branch/jump taken.
- redirect_target_i  in  XLEN  redirect destination.
- trap_i  in  1  trap request.
- trap_vec_i  in  XLEN  trap handler address.
- ras_push_i  in  1  call: push pc_o+INC.
- ras_pop_i  in  1  return: pop top.
- pc_o  out  XLEN  current fetch PC.
- pc_valid_o  out  1  pc_o is a valid fetch address.
- misalign_o  out  1  redirect target rejected (one-cycle pulse).
- ras_top_o  out  XLEN  current RAS top entry.
- ras_empty_o  out  1  RAS holds no entries.

## Operation
- States: BOOT, RUN. Reset forces BOOT; BOOT → RUN unconditionally on the next clk edge; RUN never leaves except via reset.
- BOOT: pc_o = RESET_VEC, pc_valid_o = 0, all inputs ignored.
- RUN, next-PC priority (highest first): trap_i → trap_vec_i; redirect_valid_i with target[1:0]==0 → redirect_target_i; redirect_valid_i with target[1:0]!=0 → PC holds, misalign_o=1 next cycle; stall_i → hold; else pc_o+INC.
- trap_i and redirect_i override stall_i; trap_i also suppresses misalign_o.
- trap_vec_i is not alignment-checked; low two bits forced to 0 on load.
- Increment is modulo 2^XLEN: all-ones-minus-3 + 4 wraps to 0, no flag.
- pc_valid_o = 1 in RUN.

## Timing
- Reset values: pc_o=RESET_VEC, pc_valid_o=0, misalign_o=0, ras_empty_o=1, ras_top_o=0, RAS count=0.
- Reset asserted mid-operation clears all state immediately (asynchronous), regardless of pending redirect/trap/RAS ops.
- Redirect/trap: target visible on pc_o one cycle after the sampling edge; no bubble.
- misalign_o: registered, high exactly one cycle following the offending edge.
- RAS push/pop sampled only in RUN and when stall_i=0.

## Configuration
- PC_RAS_EN defined: RAS_DEPTH-entry circular return-address stack. Push writes pc_o+INC, count saturates at RAS_DEPTH; push when full overwrites oldest. Pop decrements count; pop when empty is ignored, ras_top_o unchanged. Simultaneous push+pop replaces top, count unchanged. ras_top_o/ras_empty_o registered, update one cycle after the op.
- Undefined: no RAS storage; ras_push_i/ras_pop_i ignored; ras_top_o=0, ras_empty_o=1 constant. Ports remain for a fixed interface.

## Structure
- Shared package: state enum (BOOT, RUN), alignment mask constant, default RESET_VEC.
- One sub-module: pc_ras (stack storage, pointer, count), instantiated only under PC_RAS_EN.

## Test plan
- Reset with RESET_VEC=0x1000, release: cycle 1 pc_o=0x1000 valid=0; then 0x1000 valid=1, 0x1004, 0x1008.
- stall_i high 3 cycles at 0x1008 → pc_o holds 0x1008; redirect 0x2000 during stall → pc_o=0x2000 next cycle.
- Redirect 0x2002 → pc_o holds, misalign_o pulses one cycle; trap_i with same redirect → pc_o=trap_vec_i, misalign_o=0.
- PC=0xFFFF_FFFF_FFFF_FFFC, no stall → pc_o=0 next cycle.
- PC_RAS_EN, RAS_DEPTH=4: five pushes at 0x100,0x200,... → ras_top_o=0x504, count 4; four pops → ras_empty_o=1; extra pop → no change.
- Reset asserted mid-push/redirect → pc_o=RESET_VEC, ras_empty_o=1 immediately, before next edge.
